pfstride: RTL and testbench
===========================

PFSTRIDE -- requirements
Module: pfstride

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, stride-table entries (power of two).
REQ-002 SHALL have parameter PCBITS, default 12, width of the demand PC hash.
REQ-003 SHALL have parameter DIST, default 2, prefetch distance in strides.
REQ-004 SHALL have parameter L2_STRIDE, default 256, byte stride magnitude at or above which the prefetch targets L2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 dmtopf_valid  in  1  demand access valid.
REQ-008 dmtopf_retry  out  1  demand access back-pressure.
REQ-009 dmtopf_pc  in  PCBITS  PC hash of the demand access.
REQ-010 dmtopf_paddr  in  PADDR_BITS  demand physical byte address.
REQ-011 mptopf_op_valid  out  1  prefetch op valid toward the prefetch engine.
REQ-012 mptopf_op_retry  in  1  prefetch engine back-pressure.
REQ-013 mptopf_op  out  I_mqtopf_op_type  prefetch op {paddr, pf_l2}.
REQ-014 pfs_issued  out  16  ops handed off, saturating.
REQ-015 pfs_dropped  out  16  ops dropped, saturating.

Function
REQ-016 A transfer on either channel SHALL occur exactly when valid=1 and retry=0 in the same cycle.
REQ-017 dmtopf_retry SHALL equal reset.
REQ-018 The table SHALL use idx = pc[log2(ENTRIES)-1:0] and tag = the remaining PC bits; each entry SHALL hold {valid, tag, last_paddr, stride (16-bit signed), state}.
REQ-019 On an accepted access that misses the table (invalid entry or tag mismatch), the entry SHALL be overwritten with last_paddr = paddr, stride = 0, state = INIT, and no op SHALL be generated.
REQ-020 On a hit, delta = paddr - last_paddr; correct = (delta == stride); a delta not representable in 16-bit signed SHALL count as incorrect and load stride = 0.
REQ-021 State transitions: INIT: correct->STEADY, else->TRANSIENT with stride = delta; TRANSIENT: correct->STEADY, else->NOSTRIDE with stride = delta; STEADY: correct->STEADY, else->INIT with stride unchanged; NOSTRIDE: correct->TRANSIENT, else->NOSTRIDE with stride = delta.
REQ-022 Every hit SHALL set last_paddr = paddr; the read-modify-write SHALL complete in the accept cycle, so back-to-back accesses to one entry SHALL see updated state.
REQ-023 An op SHALL be generated when the next state is STEADY and stride != 0, with paddr = (access paddr + DIST*stride) mod 2^PADDR_BITS.
REQ-024 pf_l2 SHALL be 1 when |stride| >= L2_STRIDE, else 0.
REQ-025 An op whose 64B line equals the line of the last generated op SHALL be suppressed and not counted.
REQ-026 Generated ops SHALL enter a 2-entry FIFO at the accept edge, making mptopf_op_valid high in the cycle after accept.
REQ-027 Enqueue SHALL be allowed when occupancy < 2 or a dequeue occurs in the same cycle; otherwise the op SHALL be dropped and pfs_dropped incremented.
REQ-028 The FIFO head SHALL hold mptopf_op stable while mptopf_op_retry = 1; pfs_issued SHALL increment on each dequeue.
REQ-029 Both counters SHALL saturate at 0xFFFF.

Reset
REQ-030 While reset = 1, SHALL clear all entry valid bits, empty the FIFO, clear the last-op line, zero both counters, and drive mptopf_op_valid = 0 and dmtopf_retry = 1.
REQ-031 Reset asserted mid-operation SHALL discard queued ops and table contents without emitting ops; mptopf_op_valid SHALL be 0 in the first cycle after reset deasserts.

Structure
REQ-032 I_mqtopf_op_type, PADDR_BITS and the INIT/TRANSIENT/STEADY/NOSTRIDE enum SHALL live in the shared scmem package.
REQ-033 The 2-entry output queue SHALL be a sub-module named pfstride_outq; the table and FSM SHALL stay in pfstride.

Verification
REQ-034 Reset: after reset, mptopf_op_valid=0, pfs_issued=0, pfs_dropped=0, dmtopf_retry=0.
REQ-035 Same PC, accesses 0x1000, 0x1040, 0x1080 -> single op paddr=0x1100, pf_l2=0, valid the cycle after the third accept; pfs_issued=1 after handoff.
REQ-036 Same PC, accesses 0x0, 0x200, 0x400 -> op paddr=0x800, pf_l2=1.
REQ-037 mptopf_op_retry held 1, PC in STEADY with stride 0x40, 4 further accesses -> head stable, 2 queued, pfs_dropped=2; release retry -> 2 ops in order.
REQ-038 Two PCs with the same idx and different tags, alternating -> continual reallocation, zero ops generated.
REQ-039 Stride +0x40 near 2^PADDR_BITS-0x40 -> generated op wraps modulo 2^PADDR_BITS; reset asserted with 2 ops queued -> both discarded.

Source files
------------

// File: rtl/scmem_pkg.sv
// Shared memory-subsystem types: physical address width, prefetch op
// bundle and the stride-detector confidence states.
package scmem;

    localparam int PADDR_BITS = 32;
    localparam int LINE_BITS  = 6;

    typedef struct packed {
        logic [PADDR_BITS-1:0] paddr;
        logic                  pf_l2;
    } I_mqtopf_op_type;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        TRANSIENT = 2'd1,
        STEADY    = 2'd2,
        NOSTRIDE  = 2'd3
    } pf_state_t;

    // Magnitude of a 16-bit signed stride; 17 bits so -32768 fits.
    function automatic logic [16:0] stride_mag(input logic [15:0] s);
        logic [16:0] m;
        if (s[15])
            m = 17'd0 - {1'b1, s};
        else
            m = {1'b0, s};
        return m;
    endfunction

endpackage

// File: rtl/pfstride_outq.sv
// Two-entry prefetch op queue; the head stays put until it is popped.
module pfstride_outq
    import scmem::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  I_mqtopf_op_type push_op,
    input  logic            pop,
    output logic            valid,
    output logic            full,
    output I_mqtopf_op_type head
);

    logic [1:0]      count;
    I_mqtopf_op_type slot0;
    I_mqtopf_op_type slot1;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        slot0 <= push_op;
                    else
                        slot1 <= push_op;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_op;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_op;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign full  = (count == 2'd2);
    assign head  = slot0;

endmodule

// File: rtl/pfstride.sv
// PC-indexed stride prefetcher: per-PC confidence FSM, next-op line
// filter and a small output queue toward the prefetch engine.
module pfstride
    import scmem::*;
#(
    parameter int ENTRIES   = 8,
    parameter int PCBITS    = 12,
    parameter int DIST      = 2,
    parameter int L2_STRIDE = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dmtopf_valid,
    output logic                  dmtopf_retry,
    input  logic [PCBITS-1:0]     dmtopf_pc,
    input  logic [PADDR_BITS-1:0] dmtopf_paddr,
    output logic                  mptopf_op_valid,
    input  logic                  mptopf_op_retry,
    output I_mqtopf_op_type       mptopf_op,
    output logic [15:0]           pfs_issued,
    output logic [15:0]           pfs_dropped
);

    localparam int IDXB = $clog2(ENTRIES);
    localparam int TAGB = PCBITS - IDXB;
    localparam int LINEW = PADDR_BITS - LINE_BITS;

    logic [ENTRIES-1:0]    tbl_valid;
    logic [TAGB-1:0]       tbl_tag   [ENTRIES];
    logic [PADDR_BITS-1:0] tbl_last  [ENTRIES];
    logic [15:0]           tbl_stride[ENTRIES];
    pf_state_t             tbl_state [ENTRIES];

    logic [IDXB-1:0]       idx;
    logic [TAGB-1:0]       tag;
    logic                  accept;
    logic                  hit;
    logic [PADDR_BITS-1:0] delta;
    logic                  fits;
    logic [15:0]           cur_stride;
    pf_state_t             cur_state;
    logic                  correct;
    logic [15:0]           load_stride;
    pf_state_t             next_state;
    logic [15:0]           next_stride;

    assign dmtopf_retry = reset;
    assign accept       = dmtopf_valid & ~reset;

    assign idx = dmtopf_pc[IDXB-1:0];
    assign tag = dmtopf_pc[PCBITS-1:IDXB];
    assign hit = tbl_valid[idx] && (tbl_tag[idx] == tag);

    assign cur_stride = tbl_stride[idx];
    assign cur_state  = tbl_state[idx];
    assign delta      = dmtopf_paddr - tbl_last[idx];

    // Delta fits in 16-bit signed when all upper bits match the sign bit.
    assign fits = (&delta[PADDR_BITS-1:15]) | ~(|delta[PADDR_BITS-1:15]);
    assign correct     = fits && (delta[15:0] == cur_stride);
    assign load_stride = fits ? delta[15:0] : 16'd0;

    always_comb begin
        next_state  = cur_state;
        next_stride = cur_stride;
        unique case (cur_state)
            INIT: begin
                if (correct) begin
                    next_state = STEADY;
                end else begin
                    next_state  = TRANSIENT;
                    next_stride = load_stride;
                end
            end
            TRANSIENT: begin
                if (correct) begin
                    next_state = STEADY;
                end else begin
                    next_state  = NOSTRIDE;
                    next_stride = load_stride;
                end
            end
            STEADY: begin
                if (!correct)
                    next_state = INIT;
            end
            NOSTRIDE: begin
                if (correct) begin
                    next_state = TRANSIENT;
                end else begin
                    next_state  = NOSTRIDE;
                    next_stride = load_stride;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tbl_valid <= '0;
        end else if (accept) begin
            tbl_valid[idx] <= 1'b1;
            tbl_tag[idx]   <= tag;
            tbl_last[idx]  <= dmtopf_paddr;
            if (hit) begin
                tbl_stride[idx] <= next_stride;
                tbl_state[idx]  <= next_state;
            end else begin
                tbl_stride[idx] <= 16'd0;
                tbl_state[idx]  <= INIT;
            end
        end
    end

    logic [PADDR_BITS-1:0] stride_ext;
    logic [PADDR_BITS-1:0] target;
    logic                  gen;
    logic                  dup;
    logic                  emit;
    logic                  deq;
    logic                  q_full;
    logic                  enq;
    logic                  drop;
    logic [LINEW-1:0]      last_line;
    logic                  last_line_valid;
    I_mqtopf_op_type       new_op;

    assign stride_ext = {{(PADDR_BITS-16){next_stride[15]}}, next_stride};
    assign target     = dmtopf_paddr + stride_ext * PADDR_BITS'(DIST);

    assign gen = accept && hit && (next_state == STEADY)
              && (next_stride != 16'd0);

    assign new_op.paddr = target;
    assign new_op.pf_l2 = stride_mag(next_stride) >= 17'(L2_STRIDE);

    // Repeat requests for the same 64B line add nothing downstream.
    assign dup  = last_line_valid
               && (target[PADDR_BITS-1:LINE_BITS] == last_line);
    assign emit = gen & ~dup;
    assign deq  = mptopf_op_valid & ~mptopf_op_retry;
    assign enq  = emit & (~q_full | deq);
    assign drop = emit & q_full & ~deq;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_line_valid <= 1'b0;
            last_line       <= '0;
            pfs_issued      <= 16'd0;
            pfs_dropped     <= 16'd0;
        end else begin
            if (emit) begin
                last_line_valid <= 1'b1;
                last_line       <= target[PADDR_BITS-1:LINE_BITS];
            end
            if (deq && pfs_issued != 16'hFFFF)
                pfs_issued <= pfs_issued + 16'd1;
            if (drop && pfs_dropped != 16'hFFFF)
                pfs_dropped <= pfs_dropped + 16'd1;
        end
    end

    pfstride_outq u_outq (
        .clk     (clk),
        .reset   (reset),
        .push    (enq),
        .push_op (new_op),
        .pop     (deq),
        .valid   (mptopf_op_valid),
        .full    (q_full),
        .head    (mptopf_op)
    );

endmodule

// File: tb/tb_pfstride.sv
// Scoreboard bench for pfstride: directed access streams, expected ops
// queued at issue and popped by a monitor on each handoff.
module tb_pfstride;
    import scmem::*;

    logic                  clk;
    logic                  reset;
    logic                  dmtopf_valid;
    logic                  dmtopf_retry;
    logic [11:0]           dmtopf_pc;
    logic [PADDR_BITS-1:0] dmtopf_paddr;
    logic                  mptopf_op_valid;
    logic                  mptopf_op_retry;
    I_mqtopf_op_type       mptopf_op;
    logic [15:0]           pfs_issued;
    logic [15:0]           pfs_dropped;

    typedef struct {
        logic [31:0] paddr;
        logic        l2;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    pfstride dut (
        .clk             (clk),
        .reset           (reset),
        .dmtopf_valid    (dmtopf_valid),
        .dmtopf_retry    (dmtopf_retry),
        .dmtopf_pc       (dmtopf_pc),
        .dmtopf_paddr    (dmtopf_paddr),
        .mptopf_op_valid (mptopf_op_valid),
        .mptopf_op_retry (mptopf_op_retry),
        .mptopf_op       (mptopf_op),
        .pfs_issued      (pfs_issued),
        .pfs_dropped     (pfs_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && mptopf_op_valid && !mptopf_op_retry) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_op got paddr=%h l2=%b required none",
                         mptopf_op.paddr, mptopf_op.pf_l2);
            end else begin
                mon_e = expq.pop_front();
                if (mptopf_op.paddr !== mon_e.paddr
                    || mptopf_op.pf_l2 !== mon_e.l2) begin
                    errors++;
                    $display("FAIL op got paddr=%h l2=%b required paddr=%h l2=%b",
                             mptopf_op.paddr, mptopf_op.pf_l2,
                             mon_e.paddr, mon_e.l2);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_op(input logic [31:0] a, input logic l2);
        exp_t e;
        e.paddr = a;
        e.l2    = l2;
        expq.push_back(e);
    endtask

    task automatic access(input logic [11:0] pc, input logic [31:0] a);
        dmtopf_valid = 1'b1;
        dmtopf_pc    = pc;
        dmtopf_paddr = a;
        @(posedge clk);
        #1;
        dmtopf_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        dmtopf_valid    = 1'b0;
        dmtopf_pc       = '0;
        dmtopf_paddr    = '0;
        mptopf_op_retry = 1'b0;
        idle(3);
        check("retry_in_reset", 32'(dmtopf_retry), 32'd1);
        check("valid_in_reset", 32'(mptopf_op_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_valid", 32'(mptopf_op_valid), 32'd0);
        check("reset_retry", 32'(dmtopf_retry), 32'd0);
        check("reset_issued", 32'(pfs_issued), 32'd0);
        check("reset_dropped", 32'(pfs_dropped), 32'd0);

        // Positive stride 0x40, small: L1 target.
        access(12'h010, 32'h1000);
        check("s1_no_op_miss", 32'(mptopf_op_valid), 32'd0);
        access(12'h010, 32'h1040);
        check("s1_no_op_init", 32'(mptopf_op_valid), 32'd0);
        expect_op(32'h1100, 1'b0);
        access(12'h010, 32'h1080);
        check("s1_valid_next", 32'(mptopf_op_valid), 32'd1);
        idle(3);
        check("s1_issued", 32'(pfs_issued), 32'd1);

        // Back-pressure: two queued, two dropped, head stable.
        mptopf_op_retry = 1'b1;
        expect_op(32'h1140, 1'b0);
        expect_op(32'h1180, 1'b0);
        access(12'h010, 32'h10C0);
        check("bp_head0", mptopf_op.paddr, 32'h1140);
        access(12'h010, 32'h1100);
        access(12'h010, 32'h1140);
        check("bp_head1", mptopf_op.paddr, 32'h1140);
        access(12'h010, 32'h1180);
        check("bp_head2", mptopf_op.paddr, 32'h1140);
        check("bp_dropped", 32'(pfs_dropped), 32'd2);
        check("bp_issued_hold", 32'(pfs_issued), 32'd1);
        mptopf_op_retry = 1'b0;
        idle(4);
        check("bp_issued", 32'(pfs_issued), 32'd3);
        check("bp_drained", 32'(expq.size()), 32'd0);

        // Stride 0x200 targets L2.
        access(12'h021, 32'h0);
        access(12'h021, 32'h200);
        expect_op(32'h800, 1'b1);
        access(12'h021, 32'h400);
        idle(3);
        check("l2_issued", 32'(pfs_issued), 32'd4);

        // Negative stride.
        access(12'h034, 32'h5000);
        access(12'h034, 32'h4FC0);
        expect_op(32'h4F00, 1'b0);
        access(12'h034, 32'h4F80);
        idle(3);
        check("neg_issued", 32'(pfs_issued), 32'd5);

        // Stride 8: ops within one 64B line are filtered.
        access(12'h045, 32'h6000);
        access(12'h045, 32'h6008);
        expect_op(32'h6020, 1'b0);
        access(12'h045, 32'h6010);
        access(12'h045, 32'h6018);
        access(12'h045, 32'h6020);
        access(12'h045, 32'h6028);
        expect_op(32'h6040, 1'b0);
        access(12'h045, 32'h6030);
        idle(3);
        check("dup_issued", 32'(pfs_issued), 32'd7);
        check("dup_dropped", 32'(pfs_dropped), 32'd2);

        // Aliasing PCs keep reallocating one entry.
        for (int i = 0; i < 3; i++) begin
            access(12'h003, 32'h2000 + 32'(i) * 32'h40);
            check("alias_a", 32'(mptopf_op_valid), 32'd0);
            access(12'h013, 32'h3000 + 32'(i) * 32'h40);
            check("alias_b", 32'(mptopf_op_valid), 32'd0);
        end
        idle(2);
        check("alias_issued", 32'(pfs_issued), 32'd7);

        // Target wraps modulo 2^PADDR_BITS.
        access(12'h056, 32'hFFFF_FF40);
        access(12'h056, 32'hFFFF_FF80);
        expect_op(32'h40, 1'b0);
        access(12'h056, 32'hFFFF_FFC0);
        idle(3);
        check("wrap_issued", 32'(pfs_issued), 32'd8);

        // Reset with two ops queued discards them and the table.
        mptopf_op_retry = 1'b1;
        access(12'h056, 32'h0);
        access(12'h056, 32'h40);
        check("rst_head", mptopf_op.paddr, 32'h80);
        check("rst_full_valid", 32'(mptopf_op_valid), 32'd1);
        reset = 1'b1;
        idle(1);
        check("rst_valid_during", 32'(mptopf_op_valid), 32'd0);
        check("rst_retry_during", 32'(dmtopf_retry), 32'd1);
        mptopf_op_retry = 1'b0;
        idle(1);
        reset = 1'b0;
        #1;
        check("rst_valid_after", 32'(mptopf_op_valid), 32'd0);
        check("rst_issued", 32'(pfs_issued), 32'd0);
        check("rst_dropped", 32'(pfs_dropped), 32'd0);
        idle(3);
        check("rst_no_emit", 32'(mptopf_op_valid), 32'd0);
        access(12'h056, 32'h80);
        check("rst_table_miss", 32'(mptopf_op_valid), 32'd0);
        access(12'h056, 32'hC0);
        check("rst_table_init", 32'(mptopf_op_valid), 32'd0);
        idle(3);
        check("final_queue", 32'(expq.size()), 32'd0);
        check("final_issued", 32'(pfs_issued), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
